// File: rtl/bcminer_array.sv
// bcminer_array
//   Multi-lane mining controller. One accepted block (hash state, nonce base,
//   difficulty) is swept over 2^COUNTBITS nonces, issued NCORES at a time to
//   external hash lanes. Returned hashes are checked against a leading-zero
//   difficulty and winning nonces are queued in a small FIFO for the consumer.
//
// Ports
//   clk, rst            : single clock, synchronous active-high reset
//   blkValid/blkReady   : block handshake; blkState/blkNonceBase/blkDifficulty
//   laneValid/laneNew   : per-lane issue strobe, first-step marker
//   laneState/laneNonce : held block state and per-lane nonce
//   resValid/resHash/resNonce : lockstep lane results
//   running/done/found  : sweep status
//   nonceValid/nonceOut/nonceReady : winning-nonce FIFO drain port
//   overflow            : sticky, some winning nonce was dropped
module bcminer_array #(
  parameter int NCORES    = 4,
  parameter int COUNTBITS = 6,
  parameter int FIFODEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   blkValid,
  output logic                   blkReady,
  input  logic [351:0]           blkState,
  input  logic [31:0]            blkNonceBase,
  input  logic [7:0]             blkDifficulty,
  output logic [NCORES-1:0]      laneValid,
  output logic                   laneNew,
  output logic [351:0]           laneState,
  output logic [32*NCORES-1:0]   laneNonce,
  input  logic [NCORES-1:0]      resValid,
  input  logic [256*NCORES-1:0]  resHash,
  input  logic [32*NCORES-1:0]   resNonce,
  output logic                   running,
  output logic                   done,
  output logic                   found,
  output logic                   nonceValid,
  output logic [31:0]            nonceOut,
  input  logic                   nonceReady,
  output logic                   overflow
);

  localparam int STEPS = (2 ** COUNTBITS) / NCORES;
  localparam int CW    = COUNTBITS + 1;
  localparam int AW    = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
  localparam logic [CW-1:0] LASTSTEP = CW'(STEPS - 1);
  localparam logic [CW-1:0] STEPSV   = CW'(STEPS);
  localparam logic [AW:0]   DEPTHV   = (AW+1)'(FIFODEPTH);
  localparam logic [31:0]   NCV      = 32'(NCORES);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                 state_q;
  logic [CW-1:0]          step_q;
  logic [CW-1:0]          resCnt_q;
  logic [CW-1:0]          resCnt_d;
  logic [7:0]             diff_q;
  logic                   found_q;
  logic                   overflow_q;
  logic                   blkReady_q;
  logic                   running_q;
  logic                   done_q;
  logic [NCORES-1:0]      laneValid_q;
  logic                   laneNew_q;
  logic [351:0]           laneState_q;
  logic [32*NCORES-1:0]   laneNonce_q;

  logic [31:0]            mem_q [FIFODEPTH];
  logic [AW:0]            wrPtr_q;
  logic [AW:0]            rdPtr_q;

  logic                   active;
  logic [255:0]           zeroMask;
  logic [NCORES-1:0]      hit;
  logic [31:0]            pushData;
  logic                   multiHit;
  logic                   fifoEmpty;
  logic                   fifoFull;
  logic                   push;
  logic                   pop;
  logic                   pushOk;
  logic                   lostNonce;

  assign active    = (state_q == ISSUE) || (state_q == DRAIN);
  assign resCnt_d  = resCnt_q + CW'(active && resValid[0]);

  // The mask selects the top D hash bits; D = 0 gives an empty mask so every
  // valid result counts as a hit. Lanes are scanned high to low so the
  // lowest-index hitting lane ends up as the FIFO candidate.
  always_comb begin
    zeroMask = ~({256{1'b1}} >> diff_q);
    hit      = '0;
    pushData = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (active && resValid[i] && ((resHash[256*i +: 256] & zeroMask) == '0)) begin
        hit[i]   = 1'b1;
        pushData = resNonce[32*i +: 32];
      end
    end
  end

  // More than one hit in a cycle: only one can be queued, the rest are lost.
  assign multiHit  = |(hit & (hit - NCORES'(1)));
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = ((wrPtr_q - rdPtr_q) == DEPTHV);
  assign push      = |hit;
  assign pop       = !fifoEmpty && nonceReady;
  assign pushOk    = push && (!fifoFull || pop);
  assign lostNonce = multiHit || (push && fifoFull && !pop);

  // Sweep controller. Status outputs are registered and updated together with
  // the state so they always describe the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      resCnt_q    <= '0;
      diff_q      <= '0;
      found_q     <= 1'b0;
      blkReady_q  <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      laneValid_q <= '0;
      laneNew_q   <= 1'b0;
      laneState_q <= '0;
      laneNonce_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (blkValid) begin
            state_q     <= ISSUE;
            step_q      <= '0;
            resCnt_q    <= '0;
            diff_q      <= blkDifficulty;
            found_q     <= 1'b0;
            blkReady_q  <= 1'b0;
            running_q   <= 1'b1;
            done_q      <= 1'b0;
            laneValid_q <= '1;
            laneNew_q   <= 1'b1;
            laneState_q <= blkState;
            for (int i = 0; i < NCORES; i++) begin
              laneNonce_q[32*i +: 32] <= blkNonceBase + 32'(i);
            end
          end
        end
        ISSUE: begin
          resCnt_q  <= resCnt_d;
          laneNew_q <= 1'b0;
          if (|hit) found_q <= 1'b1;
          if (step_q == LASTSTEP) begin
            state_q     <= DRAIN;
            laneValid_q <= '0;
          end else begin
            step_q <= step_q + CW'(1);
            for (int i = 0; i < NCORES; i++) begin
              laneNonce_q[32*i +: 32] <= laneNonce_q[32*i +: 32] + NCV;
            end
          end
        end
        DRAIN: begin
          resCnt_q <= resCnt_d;
          if (|hit) found_q <= 1'b1;
          if (resCnt_d == STEPSV) begin
            state_q    <= DONE;
            running_q  <= 1'b0;
            done_q     <= 1'b1;
            blkReady_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO pointers carry one extra bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pushOk) wrPtr_q <= wrPtr_q + (AW+1)'(1);
      if (pop) rdPtr_q <= rdPtr_q + (AW+1)'(1);
      if (lostNonce) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset; the head is only presented while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (pushOk) mem_q[wrPtr_q[AW-1:0]] <= pushData;
  end

  assign blkReady   = blkReady_q;
  assign laneValid  = laneValid_q;
  assign laneNew    = laneNew_q;
  assign laneState  = laneState_q;
  assign laneNonce  = laneNonce_q;
  assign running    = running_q;
  assign done       = done_q;
  assign found      = found_q;
  assign overflow   = overflow_q;
  assign nonceValid = !fifoEmpty;
  assign nonceOut   = fifoEmpty ? 32'h0 : mem_q[rdPtr_q[AW-1:0]];

endmodule
